// File: rtl/adder_pkg.sv
// Shared constants and operand-bus helpers for the shared adder.
package adder_pkg;

   localparam int ADD_W    = 16;
   localparam int NREQ_MAX = 8;
   localparam int REQ_ID_W = 3;
   localparam int BUS_W    = NREQ_MAX * ADD_W;

   typedef logic [REQ_ID_W-1:0] req_id_t;

   function automatic logic [ADD_W-1:0] opnd_slice(
      input logic [BUS_W-1:0] vec,
      input req_id_t          idx
   );
      return vec[int'(idx)*ADD_W +: ADD_W];
   endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester and response bundle of the shared adder.
interface adder_share_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   import adder_pkg::*;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*ADD_W-1:0] req_a;
   logic [NREQ*ADD_W-1:0] req_b;
   logic [NREQ-1:0]       req_cin;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [ADD_W-1:0]      rsp_sum;
   logic                  rsp_cout;
   logic [ADD_W-1:0]      busy_cnt;

   modport master (
      output req_valid, req_a, req_b, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout,
      input  busy_cnt
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout,
      output busy_cnt
   );

endinterface

// File: rtl/adder16.sv
// 16-bit ripple-carry adder.
module adder16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [16:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 16; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[16];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search upward from ptr with wrap-around.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx
);

   int   j;
   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (en && !found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// One adder16 shared round-robin between NREQ requesters,
// with a one-entry result register tagged by requester id.
module adder_share_arbiter
   import adder_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   adder_share_arbiter_if.slave bus
);

   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   id_q;
   logic             arb_en;
   logic             take;
   logic [BUS_W-1:0] a_ext;
   logic [BUS_W-1:0] b_ext;
   logic [ADD_W-1:0] op_a;
   logic [ADD_W-1:0] op_b;
   logic             op_cin;
   logic [ADD_W-1:0] sum;
   logic             cout;
   logic             vld_q;
   logic [ADD_W-1:0] sum_q;
   logic             cout_q;
   logic [ADD_W-1:0] cnt_q;

   // Draining and refilling the slot in one cycle keeps 1 add/cycle.
   assign arb_en = rst_n & (~vld_q | bus.rsp_ready);

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req (bus.req_valid),
      .ptr (ptr_q),
      .en  (arb_en),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   assign take   = |gnt;
   assign a_ext  = BUS_W'(bus.req_a);
   assign b_ext  = BUS_W'(bus.req_b);
   assign op_a   = opnd_slice(a_ext, req_id_t'(gnt_idx));
   assign op_b   = opnd_slice(b_ext, req_id_t'(gnt_idx));
   assign op_cin = bus.req_cin[gnt_idx];

   adder16 u_add (
      .a    (op_a),
      .b    (op_b),
      .cin  (op_cin),
      .sum  (sum),
      .cout (cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (take) begin
         ptr_q <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         id_q   <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (take) begin
         vld_q  <= 1'b1;
         id_q   <= gnt_idx;
         sum_q  <= sum;
         cout_q <= cout;
      end else if (bus.rsp_ready) begin
         vld_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (take && cnt_q != '1) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign bus.req_ready = gnt;
   assign bus.rsp_valid = vld_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_sum   = sum_q;
   assign bus.rsp_cout  = cout_q;
   assign bus.busy_cnt  = cnt_q;

   // Requesters must not withdraw or alter a request until granted.
   for (genvar i = 0; i < NREQ; i++) begin : g_hold
      a_hold: assert property (
         @(posedge clk) disable iff (!rst_n)
         bus.req_valid[i] && !bus.req_ready[i] |=>
            bus.req_valid[i] &&
            $stable(bus.req_a[i*ADD_W +: ADD_W]) &&
            $stable(bus.req_b[i*ADD_W +: ADD_W]) &&
            $stable(bus.req_cin[i]));
   end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a cycle-level
// reference model checked every falling edge.
module tb_adder_share_arbiter;
   import adder_pkg::*;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   errors  = 0;

   adder_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   adder_share_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference model: what the outputs must be after each edge.
   int              m_ptr = 0;
   bit              m_vld = 0;
   int              m_id  = 0;
   logic [15:0]     m_sum = '0;
   bit              m_cout = 0;
   logic [15:0]     m_cnt = '0;
   int              g;
   int              j;
   logic [16:0]     s;
   logic [NREQ-1:0] er;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         m_ptr = 0; m_vld = 0; m_id = 0;
         m_sum = '0; m_cout = 0; m_cnt = '0;
         chk("rst_ready", 32'(bus.req_ready), 32'(0));
         chk("rst_valid", 32'(bus.rsp_valid), 32'(0));
         chk("rst_cnt", 32'(bus.busy_cnt), 32'(0));
      end else begin
         g = -1;
         if (!m_vld || bus.rsp_ready) begin
            for (int k = 0; k < NREQ; k++) begin
               j = (m_ptr + k) % NREQ;
               if (g < 0 && bus.req_valid[j]) g = j;
            end
         end
         er = (g >= 0) ? (NREQ'(1) << g) : '0;
         chk("m_ready", 32'(bus.req_ready), 32'(er));
         chk("m_valid", 32'(bus.rsp_valid), 32'(m_vld));
         chk("m_id",    32'(bus.rsp_id),    32'(m_id));
         chk("m_sum",   32'(bus.rsp_sum),   32'(m_sum));
         chk("m_cout",  32'(bus.rsp_cout),  32'(m_cout));
         chk("m_cnt",   32'(bus.busy_cnt),  32'(m_cnt));
         if (g >= 0) begin
            s = {1'b0, bus.req_a[g*16 +: 16]}
              + {1'b0, bus.req_b[g*16 +: 16]}
              + 17'(bus.req_cin[g]);
            m_sum  = s[15:0];
            m_cout = s[16];
            m_id   = g;
            m_vld  = 1;
            m_ptr  = (g + 1) % NREQ;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end else if (m_vld && bus.rsp_ready) begin
            m_vld = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic single(input int id, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
      bus.req_valid[id]      = 1'b1;
      bus.req_a[id*16 +: 16] = a;
      bus.req_b[id*16 +: 16] = b;
      bus.req_cin[id]        = c;
      step();
      bus.req_valid[id]      = 1'b0;
   endtask

   task automatic rsp(input string nm, input int id,
                      input logic [15:0] sm, input logic co);
      chk({nm, "_valid"}, 32'(bus.rsp_valid), 32'(1));
      chk({nm, "_id"},    32'(bus.rsp_id),    32'(id));
      chk({nm, "_sum"},   32'(bus.rsp_sum),   32'(sm));
      chk({nm, "_cout"},  32'(bus.rsp_cout),  32'(co));
   endtask

   logic [15:0] rr_sum [NREQ];
   int          rr_ids [5];
   int          bp_ids [4];

   initial begin
      rr_sum = '{16'h1211, 16'h2324, 16'h3435, 16'h4548};
      rr_ids = '{0, 1, 2, 3, 0};
      bp_ids = '{1, 2, 3, 0};
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_cin   = '0;
      bus.rsp_ready = 1'b1;
      #2;
      chk("init_valid", 32'(bus.rsp_valid), 32'(0));
      chk("init_sum",   32'(bus.rsp_sum),   32'(0));
      chk("init_cnt",   32'(bus.busy_cnt),  32'(0));
      step();
      step();
      rst_n = 1'b1;
      step();

      single(0, 16'h1234, 16'h0FF1, 1'b0);
      rsp("add", 0, 16'h2225, 1'b0);
      single(0, 16'hFFFF, 16'h0001, 1'b0);
      rsp("wrap", 0, 16'h0000, 1'b1);
      single(0, 16'h0005, ~16'h0003, 1'b1);
      rsp("sub", 0, 16'h0002, 1'b1);
      chk("cnt3", 32'(bus.busy_cnt), 32'(3));
      single(1, 16'h0101, 16'h0202, 1'b0);
      rsp("req1", 1, 16'h0303, 1'b0);

      // Async reset mid-cycle with a result pending, pointer at 2.
      bus.req_a[16 +: 16] = 16'h0AAA;
      bus.req_b[16 +: 16] = 16'h0001;
      bus.req_cin[1]      = 1'b0;
      bus.req_a[48 +: 16] = 16'h0BBB;
      bus.req_b[48 +: 16] = 16'h0002;
      bus.req_cin[3]      = 1'b1;
      bus.req_valid       = 4'b1010;
      rst_n               = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.rsp_valid), 32'(0));
      chk("arst_id",    32'(bus.rsp_id),    32'(0));
      chk("arst_sum",   32'(bus.rsp_sum),   32'(0));
      chk("arst_cout",  32'(bus.rsp_cout),  32'(0));
      chk("arst_cnt",   32'(bus.busy_cnt),  32'(0));
      chk("arst_ready", 32'(bus.req_ready), 32'(0));
      step();
      step();
      rst_n = 1'b1;
      step();
      rsp("post_rst1", 1, 16'h0AAB, 1'b0);
      bus.req_valid[1] = 1'b0;
      step();
      rsp("post_rst3", 3, 16'h0BBE, 1'b0);
      bus.req_valid[3] = 1'b0;

      // Round-robin with all four requesting continuously.
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*16 +: 16] = 16'h1111 * 16'(i + 1);
         bus.req_b[i*16 +: 16] = 16'h0100 + 16'(i);
         bus.req_cin[i]        = i[0];
      end
      bus.req_valid = 4'b1111;
      foreach (rr_ids[n]) begin
         step();
         rsp($sformatf("rr%0d", n), rr_ids[n], rr_sum[rr_ids[n]], 1'b0);
      end

      // Backpressure: slot full, nothing may be granted.
      bus.rsp_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("bp_ready", 32'(bus.req_ready), 32'(0));
         rsp($sformatf("bp%0d", n), 0, 16'h1211, 1'b0);
      end
      bus.rsp_ready = 1'b1;
      foreach (bp_ids[n]) begin
         step();
         rsp($sformatf("rel%0d", n), bp_ids[n], rr_sum[bp_ids[n]], 1'b0);
         bus.req_valid[bp_ids[n]] = 1'b0;
      end
      step();
      chk("drain_valid", 32'(bus.rsp_valid), 32'(0));
      chk("cnt11", 32'(bus.busy_cnt), 32'(11));

      // Saturation of the handshake counter.
      force dut.cnt_q = 16'hFFFE;
      #1;
      release dut.cnt_q;
      m_cnt = 16'hFFFE;
      chk("cnt_fffe", 32'(bus.busy_cnt), 32'(16'hFFFE));
      for (int n = 0; n < 3; n++) begin
         single(2, 16'h0010, 16'(n), 1'b0);
         chk($sformatf("sat%0d", n), 32'(bus.busy_cnt), 32'(16'hFFFF));
      end
      rsp("sat_last", 2, 16'h0012, 1'b0);
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
